// File: rtl/midi_rx_ctrl.sv
// midi_rx_ctrl: 31.25 kbaud 8-N-1 MIDI receiver that sequences an external
// baud tick generator (enable + period) and delivers bytes as valid pulses.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | generator off, period = half bit, waiting for a 1->0 edge
// S_START | generator on; first tick skipped, second tick checks mid-start
// S_DATA  | full-bit period; each tick shifts one data bit in, LSB first
// S_STOP  | next tick samples the stop bit, then emits byte or frame error
module midi_rx_ctrl #(
    parameter int DIV_FULL = 3200,
    parameter int DIV_HALF = DIV_FULL / 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rx_i,
    input  logic        tick_i,
    output logic        baud_en_o,
    output logic [11:0] baud_div_o,
    output logic [7:0]  data_o,
    output logic        data_valid_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [11:0] DIV_FULL_C = 12'(DIV_FULL);
    localparam logic [11:0] DIV_HALF_C = 12'(DIV_HALF);

    state_t      state_q;
    logic        rx_m_q;
    logic        rx_s_q;
    logic        rx_p_q;
    logic        skip_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic        start_edge;
    logic        baud_en_q;
    logic [11:0] baud_div_q;
    logic [7:0]  data_q;
    logic        data_valid_q;
    logic        frame_err_q;
    logic        busy_q;

    // Two-flop synchronizer plus one delayed copy for start-edge detection.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
            rx_p_q <= 1'b1;
        end else begin
            rx_m_q <= rx_i;
            rx_s_q <= rx_m_q;
            rx_p_q <= rx_s_q;
        end
    end

    assign start_edge = rx_p_q & ~rx_s_q;
    assign shift_d    = {rx_s_q, shift_q[7:1]};

    // Frame sequencer; every output is registered here.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            skip_q       <= 1'b0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            baud_en_q    <= 1'b0;
            baud_div_q   <= DIV_HALF_C;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        state_q   <= S_START;
                        baud_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                        skip_q    <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick_i) begin
                        if (skip_q) begin
                            // First tick arrives right after enable; not mid-bit.
                            skip_q <= 1'b0;
                        end else if (!rx_s_q) begin
                            state_q    <= S_DATA;
                            baud_div_q <= DIV_FULL_C;
                            bit_cnt_q  <= 3'd0;
                        end else begin
                            state_q   <= S_IDLE;
                            baud_en_q <= 1'b0;
                            busy_q    <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (tick_i) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (tick_i) begin
                        if (rx_s_q) begin
                            data_q       <= shift_q;
                            data_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q    <= S_IDLE;
                        baud_en_q  <= 1'b0;
                        baud_div_q <= DIV_HALF_C;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    baud_en_q  <= 1'b0;
                    baud_div_q <= DIV_HALF_C;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign baud_en_o    = baud_en_q;
    assign baud_div_o   = baud_div_q;
    assign data_o       = data_q;
    assign data_valid_o = data_valid_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = busy_q;

endmodule

// File: doc/midi_rx_ctrl.md
# midi_rx_ctrl

MIDI serial receive controller that sequences the shared `baud_gen_midi` tick generator to frame and capture 31.25 kbaud 8-N-1 bytes. It drives the generator's `enable` and `upper_bound`, consumes its `tick`, and delivers completed bytes as single-cycle valid pulses to the MIDI message parser. The controller holds the generator disabled while the line is idle. It enables the generator on a start-bit edge and switches between half-bit and full-bit periods so that every sample lands mid-bit.

## Interface
- `DIV_FULL`, default 3200: clock cycles per bit (100 MHz / 31 250). Must be 4..4095.
- `DIV_HALF`, default `DIV_FULL/2` (truncating): cycles from the start edge to the mid-start sample.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  raw MIDI line, asynchronous, idle high.
- `tick`  in  1  pulse from the baud generator.
- `baud_en`  out  1  baud generator enable.
- `baud_div`  out  12  baud generator `upper_bound`.
- `data`  out  8  last good byte; holds its value until the next good byte.
- `data_valid`  out  1  one-cycle pulse when `data` updates.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`; all decisions use `rx_s`.
- A start edge is `rx_s` = 0 while the previous `rx_s` = 1.
- Tick contract, as delivered by the generator:
  - the first tick arrives 1 cycle after `baud_en` rises;
  - later ticks arrive every `baud_div` cycles;
  - a `baud_div` change made on the cycle after a tick takes effect on the next period;
  - dropping `baud_en` clears the generator count.
- States and transitions:
  - IDLE: `baud_en`=0, `baud_div`=`DIV_HALF`. On a start edge → START, with `baud_en`=1. A tick in IDLE is ignored.
  - START: ignore the first tick (`skip` flag). On the second tick:
    - if `rx_s`=0 → DATA, with `baud_div`=`DIV_FULL` and bit count = 0;
    - otherwise this is a false start → IDLE, with `baud_en`=0.
  - DATA: on each tick, shift `rx_s` into the shift register LSB-first and increment the 3-bit count. On the tick with count = 7 → STOP.
  - STOP: on a tick:
    - if `rx_s`=1: `data` takes the shift register and `data_valid` pulses;
    - otherwise: `frame_err` pulses and `data` is unchanged;
    - in both cases → IDLE, with `baud_en`=0 and `baud_div`=`DIV_HALF`.
- After a frame error the line may still be low. A new frame requires a fresh 1→0 edge, so a held break yields exactly one `frame_err`.
- All outputs are registered. Reset values:
  - `baud_en`=0, `baud_div`=`DIV_HALF`;
  - `data`=0x00, `data_valid`=0, `frame_err`=0, `busy`=0;
  - state = IDLE; synchronizer flops = 1.
- Reset at any point, including mid-frame, returns to IDLE within 1 cycle with no pulse emitted. A partial byte is discarded.
- `data_valid` and `frame_err` are never high in the same cycle.

## Timing
- Let T be the cycle in which `rx_s` first shows 0; the raw `rx` fell 2–3 cycles earlier.
- `baud_en`=1 from T+1. The ignored tick occurs at T+2. The mid-start sample occurs at T+2+`DIV_HALF`.
- Data bit k is sampled at T+2+`DIV_HALF`+(k+1)·`DIV_FULL`, for k=0..7.
- The stop bit is sampled at T+2+`DIV_HALF`+9·`DIV_FULL`.
- `data_valid` or `frame_err` is high in the cycle after the stop tick. `baud_en` falls in that same cycle.
- Earliest next start edge accepted: the cycle after return to IDLE. This allows back-to-back frames with zero idle time.
- A false start costs `DIV_HALF`+2 cycles in START. Glitches shorter than about `DIV_HALF` are rejected.

## Test plan
Bench instantiates `baud_gen_midi` with `DIV_FULL`=16 and `DIV_HALF`=8, and drives `rx` at 16 cycles/bit.
- Single frame 0x90 → one `data_valid` pulse with `data`=0x90, no `frame_err`, `busy` high for about 154 cycles, `baud_en` low afterwards.
- Back-to-back 0x90, 0x3C, 0x7F with no idle gap → three `data_valid` pulses with `data` 0x90, 0x3C, 0x7F in order, no errors.
- `rx` low glitch of 3 cycles → no `data_valid`, no `frame_err`, return to IDLE, `baud_en` low within about 11 cycles.
- Frame 0x55 with the stop bit driven low → one `frame_err` pulse, `data` keeps its previous value, no `data_valid`.
- `rx` held low for 500 cycles (break), then released → exactly one `frame_err`; a following 0x42 frame → `data`=0x42.
- `reset` asserted for 1 cycle during data bit 4 of 0xFF → next cycle state is IDLE, `baud_en`=0, `data`=0x00, no pulses. A following frame 0x01 is received correctly.
